uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer between the receive/echo logic and the uart_tx serializer.
- Accepts single-cycle byte strobes at any rate, stores up to DEPTH bytes, and drains them one at a time into uart_tx. Drain uses uart_tx's write_en/busy handshake.
- Removes the current byte-drop behaviour, where bytes arriving while tx is busy are lost. Bytes are dropped only when the buffer is full, and each drop is flagged.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, ≥ 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- wr_valid_i  input  1  one-cycle strobe; wr_byte_i is to be enqueued.
- wr_byte_i  input  8  byte to enqueue.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- count_o  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky; set when a strobe arrives while full.
- tx_write_en_o  output  1  one-cycle load pulse to uart_tx.
- tx_byte_o  output  8  byte presented to uart_tx; valid while tx_write_en_o = 1.
- tx_busy_i  input  1  uart_tx busy; rises the cycle after an accepted write_en.

Behaviour:
Reset
- Asynchronous reset clears the pointers, sets count_o = 0, full_o = 0, empty_o = 1, overflow_o = 0, tx_write_en_o = 0, tx_byte_o = 8'h00, and forces FSM = IDLE.
- Reset mid-transfer discards all stored bytes. No write_en is issued until a new byte is pushed after reset deasserts.

Storage
- Circular buffer of DEPTH × 8 bits. Pointers wrap naturally at DEPTH.
- count is tracked explicitly, so full and empty are unambiguous.

Push
- Occurs on a clk edge with wr_valid_i = 1 and full_o = 0 (registered value).
- Writes mem[wr_ptr], then wr_ptr++ and count++.

Overflow
- A strobe while full_o = 1 is dropped and sets overflow_o = 1. overflow_o stays set until reset.
- A push is rejected if full_o was 1 in that cycle, even when a pop occurs in the same cycle.

Pop
- Occurs in state ISSUE only: rd_ptr++ and count--.

Simultaneous push and pop (not full)
- Both take effect; count is unchanged.

Empty with push
- No fall-through. The byte becomes visible to the FSM the cycle after it is written.

FSM
- IDLE: when empty_o = 0 and tx_busy_i = 0, load tx_byte_o <= mem[rd_ptr] and go to ISSUE.
- ISSUE: tx_write_en_o = 1 for exactly this cycle; pop; go to GUARD.
- GUARD: one cycle allowing uart_tx to raise busy; go to WAIT.
- WAIT: stay while tx_busy_i = 1; go to IDLE when tx_busy_i = 0.

tx_write_en_o
- Registered; high only in ISSUE. Never high on two consecutive cycles.

tx_byte_o
- Registered. Holds its last value outside ISSUE.

Latency
- Strobe sampled at edge N gives mem write at N and empty_o = 0 after N.
- IDLE leaves at edge N+1, so tx_write_en_o is high in the cycle after edge N+1. This is 2 cycles from strobe to write_en when idle.

Back-to-back drain
- The next ISSUE occurs no earlier than 2 cycles after tx_busy_i falls: WAIT→IDLE, then IDLE→ISSUE.

Ordering
- Bytes are transmitted strictly in push order. No byte is duplicated or skipped across pointer wrap.

Test Plan:
1. Reset, then one strobe of 8'hA5 with tx_busy_i modelled by a real uart_tx (CLK_DIV_FACTOR = 25) → tx_write_en_o pulses once, 2 cycles after the strobe, with tx_byte_o = 8'hA5. Afterwards count_o = 0 and empty_o = 1.
2. Burst of 5 strobes on consecutive cycles (8'h01..8'h05) while tx is idle → count_o peaks at 4 or 5. Serial line carries 01, 02, 03, 04, 05 in order. Exactly 5 write_en pulses, each separated by a full busy period.
3. Hold tx_busy_i = 1, push 18 bytes (8'h10..8'h21) with DEPTH = 16 → full_o = 1 after the 16th. Bytes 8'h20 and 8'h21 are dropped and overflow_o = 1. Release busy → exactly 16 bytes, 10..1F, are drained.
4. Wrap-around: 3 rounds of 12 pushes and 12 drains (36 bytes through a 16-deep buffer) → output sequence equals input sequence. count_o returns to 0 after each round.
5. Full buffer with a push in the same cycle as ISSUE → that push is rejected and overflow_o is set. count_o goes from 16 to 15.
6. Assert reset while in WAIT with count_o = 7 → all outputs return to reset values immediately. After release, with no pushes, no tx_write_en_o pulse for 1000 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the echo logic and uart_tx. It buffers strobed bytes and
// drains them one at a time through the uart_tx write_en/busy handshake.
module uart_tx_fifo #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid_i,
   input  logic [7:0]       wr_byte_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o,
   output logic             overflow_o,
   output logic             tx_write_en_o,
   output logic [7:0]       tx_byte_o,
   input  logic             tx_busy_i
);

   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             r_tx_we;
   logic [7:0]       r_tx_byte;
   state_t           r_state;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   // Full is judged on the registered count, so a same-cycle pop never frees room.
   assign w_push  = wr_valid_i & ~w_full;
   assign w_pop   = (r_state == S_ISSUE);

   assign full_o        = w_full;
   assign empty_o       = w_empty;
   assign count_o       = r_count;
   assign overflow_o    = r_overflow;
   assign tx_write_en_o = r_tx_we;
   assign tx_byte_o     = r_tx_byte;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_byte_i;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (wr_valid_i && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Drain FSM: load byte, pulse write_en, give uart_tx a cycle to raise busy, wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tx_we   <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx_we <= 1'b0;
               if (!w_empty && !tx_busy_i) begin
                  r_tx_byte <= r_mem[r_rd_ptr];
                  r_tx_we   <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_tx_we <= 1'b0;
               r_state <= S_GUARD;
            end
            S_GUARD: begin
               r_tx_we <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_tx_we <= 1'b0;
               if (!tx_busy_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_tx_we <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart_tx busy model
// (busy for BUSY_CYC cycles, rising the cycle after each write_en).
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned PTR_W    = $clog2(DEPTH);
   localparam int          BUSY_CYC = 40;
   localparam int          GAP      = BUSY_CYC + 3;

   logic             clk;
   logic             reset;
   logic             wr_valid;
   logic [7:0]       wr_byte;
   logic             full_o;
   logic             empty_o;
   logic [PTR_W:0]   count_o;
   logic             overflow_o;
   logic             tx_write_en_o;
   logic [7:0]       tx_byte_o;
   logic             tx_busy;
   logic             force_busy;

   int          busy_cnt = 0;
   int          cyc      = 0;
   int          dbl      = 0;
   logic        prev_we  = 1'b0;
   logic [7:0]  cap_q [$];
   int          cap_t [$];

   int n_total = 0;
   int n_bad   = 0;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid_i    (wr_valid),
      .wr_byte_i     (wr_byte),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .count_o       (count_o),
      .overflow_o    (overflow_o),
      .tx_write_en_o (tx_write_en_o),
      .tx_byte_o     (tx_byte_o),
      .tx_busy_i     (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_busy = force_busy || (busy_cnt != 0);

   always @(posedge clk or posedge reset) begin
      if (reset)              busy_cnt <= 0;
      else if (tx_write_en_o) busy_cnt <= BUSY_CYC;
      else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
   end

   // Capture every write_en pulse with its byte and cycle stamp.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_write_en_o) begin
         cap_q.push_back(tx_byte_o);
         cap_t.push_back(cyc);
      end
      if (prev_we && tx_write_en_o) dbl <= dbl + 1;
      prev_we <= tx_write_en_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_byte  = b;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (empty_o && !tx_busy) n++;
         else n = 0;
         if (n >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("drain_done", 32'(ok), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_count"}, 32'(count_o), 32'd0);
      check_eq({tag, "_empty"}, 32'(empty_o), 32'd1);
      check_eq({tag, "_full"},  32'(full_o), 32'd0);
      check_eq({tag, "_ovf"},   32'(overflow_o), 32'd0);
      check_eq({tag, "_we"},    32'(tx_write_en_o), 32'd0);
      check_eq({tag, "_byte"},  32'(tx_byte_o), 32'h00);
   endtask

   initial begin
      int base;
      int peak;
      reset      = 1'b1;
      wr_valid   = 1'b0;
      wr_byte    = 8'h00;
      force_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;

      // 1: single byte, two-cycle latency to write_en
      base = cap_q.size();
      @(negedge clk);
      wr_valid = 1'b1;
      wr_byte  = 8'hA5;
      @(negedge clk);
      wr_valid = 1'b0;
      check_eq("t1_cnt_after_push", 32'(count_o), 32'd1);
      check_eq("t1_empty_after_push", 32'(empty_o), 32'd0);
      check_eq("t1_we_early", 32'(tx_write_en_o), 32'd0);
      @(negedge clk);
      check_eq("t1_we", 32'(tx_write_en_o), 32'd1);
      check_eq("t1_byte", 32'(tx_byte_o), 32'hA5);
      @(negedge clk);
      check_eq("t1_we_one_cycle", 32'(tx_write_en_o), 32'd0);
      check_eq("t1_cnt_after_pop", 32'(count_o), 32'd0);
      check_eq("t1_empty_after_pop", 32'(empty_o), 32'd1);
      wait_drain();
      check_eq("t1_pulses", 32'(cap_q.size() - base), 32'd1);

      // 2: burst of five consecutive strobes
      base = cap_q.size();
      peak = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (int'(count_o) > peak) peak = int'(count_o);
         wr_valid = 1'b1;
         wr_byte  = 8'(i + 1);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (int'(count_o) > peak) peak = int'(count_o);
         @(negedge clk);
      end
      check_eq("t2_peak", 32'(peak), 32'd4);
      wait_drain();
      check_eq("t2_pulses", 32'(cap_q.size() - base), 32'd5);
      for (int k = 0; k < 5; k++)
         check_eq($sformatf("t2_byte%0d", k), 32'(cap_q[base + k]), 32'(k + 1));
      for (int k = 1; k < 5; k++)
         check_eq($sformatf("t2_gap%0d", k), 32'(cap_t[base + k] - cap_t[base + k - 1]), 32'(GAP));

      // 3: overfill while busy, then drain
      base = cap_q.size();
      force_busy = 1'b1;
      for (int i = 0; i < 18; i++) begin
         push_byte(8'(8'h10 + i));
         if (i == 14) check_eq("t3_not_full15", 32'(full_o), 32'd0);
         if (i == 15) begin
            check_eq("t3_full16", 32'(full_o), 32'd1);
            check_eq("t3_cnt16", 32'(count_o), 32'd16);
            check_eq("t3_ovf_clear", 32'(overflow_o), 32'd0);
         end
      end
      check_eq("t3_cnt_after_drop", 32'(count_o), 32'd16);
      check_eq("t3_ovf_set", 32'(overflow_o), 32'd1);
      check_eq("t3_no_issue_busy", 32'(cap_q.size() - base), 32'd0);
      force_busy = 1'b0;
      wait_drain();
      check_eq("t3_pulses", 32'(cap_q.size() - base), 32'd16);
      for (int k = 0; k < 16; k++)
         check_eq($sformatf("t3_byte%0d", k), 32'(cap_q[base + k]), 32'(8'h10 + k));

      // 4: wrap-around, three rounds of twelve
      for (int r = 0; r < 3; r++) begin
         base = cap_q.size();
         for (int i = 0; i < 12; i++) push_byte(8'(8'h40 + r * 16 + i));
         wait_drain();
         check_eq($sformatf("t4_cnt_r%0d", r), 32'(count_o), 32'd0);
         check_eq($sformatf("t4_pulses_r%0d", r), 32'(cap_q.size() - base), 32'd12);
         for (int k = 0; k < 12; k++)
            check_eq($sformatf("t4_r%0d_b%0d", r, k), 32'(cap_q[base + k]), 32'(8'h40 + r * 16 + k));
      end

      // 5: push rejected in the ISSUE cycle of a full buffer
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("t5_ovf_after_rst", 32'(overflow_o), 32'd0);
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
      check_eq("t5_full", 32'(full_o), 32'd1);
      check_eq("t5_ovf_pre", 32'(overflow_o), 32'd0);
      base = cap_q.size();
      @(negedge clk);
      force_busy = 1'b0;
      @(negedge clk);
      check_eq("t5_issue", 32'(tx_write_en_o), 32'd1);
      wr_valid = 1'b1;
      wr_byte  = 8'hEE;
      @(negedge clk);
      wr_valid = 1'b0;
      check_eq("t5_cnt15", 32'(count_o), 32'd15);
      check_eq("t5_ovf", 32'(overflow_o), 32'd1);
      check_eq("t5_not_full", 32'(full_o), 32'd0);
      wait_drain();
      check_eq("t5_pulses", 32'(cap_q.size() - base), 32'd16);
      for (int k = 0; k < 16; k++)
         check_eq($sformatf("t5_byte%0d", k), 32'(cap_q[base + k]), 32'(8'h80 + k));

      // 6: reset while waiting on busy with seven bytes stored
      force_busy = 1'b1;
      for (int i = 0; i < 8; i++) push_byte(8'(8'hC0 + i));
      base = cap_q.size();
      @(negedge clk);
      force_busy = 1'b0;
      @(negedge clk);
      force_busy = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("t6_pre_cnt", 32'(count_o), 32'd7);
      check_eq("t6_pre_byte", 32'(tx_byte_o), 32'hC0);
      check_eq("t6_pre_pulses", 32'(cap_q.size() - base), 32'd1);
      #1 reset = 1'b1;
      #1 check_reset_vals("t6_async");
      @(negedge clk);
      reset      = 1'b0;
      force_busy = 1'b0;
      base = cap_q.size();
      repeat (1000) @(negedge clk);
      check_eq("t6_no_pulse", 32'(cap_q.size() - base), 32'd0);
      check_eq("t6_empty", 32'(empty_o), 32'd1);

      check_eq("no_double_we", 32'(dbl), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
